// File: rtl/demux_pkg.sv
// Shared constants for the registered 1-to-4 demultiplexer.
// Select encoding and port count are shared by the decoder and the top level.
package demux_pkg;

  localparam int DEMUX_WIDTH_DEFAULT = 3;
  localparam int N_PORTS             = 4;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

endpackage

// File: rtl/demux_1to4_dec.sv
// Combinational 2-to-4 one-hot decoder with enable.
// The output is all-zero whenever en is low.
module demux_1to4_dec
  import demux_pkg::*;
(
  input  logic [1:0]         sel,
  input  logic               en,
  output logic [N_PORTS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      case (sel)
        SEL_A:   onehot = 4'b0001;
        SEL_B:   onehot = 4'b0010;
        SEL_C:   onehot = 4'b0100;
        SEL_D:   onehot = 4'b1000;
        default: onehot = '0;
      endcase
    end
  end

endmodule

// File: rtl/demux_1to4.sv
// Registered 1-to-4 demultiplexer: steers one word to port A/B/C/D by sel.
// Unselected ports are zeroed every cycle; out_vld is the registered one-hot select.
module demux_1to4
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         sel,
  input  logic [WIDTH-1:0]   in,
  input  logic               in_vld,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [WIDTH-1:0]   C,
  output logic [WIDTH-1:0]   D,
  output logic [N_PORTS-1:0] out_vld
);

  logic [N_PORTS-1:0] hot;
  logic [WIDTH-1:0]   a_nxt;
  logic [WIDTH-1:0]   b_nxt;
  logic [WIDTH-1:0]   c_nxt;
  logic [WIDTH-1:0]   d_nxt;

  demux_1to4_dec u_dec (
    .sel    (sel),
    .en     (in_vld),
    .onehot (hot)
  );

  // Masking with the decoder bits zeroes every unselected port, so no data is held.
  always_comb begin
    a_nxt = in & {WIDTH{hot[0]}};
    b_nxt = in & {WIDTH{hot[1]}};
    c_nxt = in & {WIDTH{hot[2]}};
    d_nxt = in & {WIDTH{hot[3]}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A       <= '0;
      B       <= '0;
      C       <= '0;
      D       <= '0;
      out_vld <= '0;
    end else begin
      A       <= a_nxt;
      B       <= b_nxt;
      C       <= c_nxt;
      D       <= d_nxt;
      out_vld <= hot;
    end
  end

endmodule

// File: tb/tb_demux_1to4.sv
// Self-checking bench for demux_1to4 at WIDTH=3 and WIDTH=8.
// Expected outputs come from a rule-based reference model of the steering behaviour.
module tb_demux_1to4;
  import demux_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sel;
  logic       in_vld;
  logic [2:0] in3;
  logic [7:0] in8;

  logic [2:0] a3, b3, c3, d3;
  logic [3:0] ov3;
  logic [7:0] a8, b8, c8, d8;
  logic [3:0] ov8;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  demux_1to4 #(.WIDTH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .in(in3), .in_vld(in_vld),
    .A(a3), .B(b3), .C(c3), .D(d3), .out_vld(ov3)
  );

  demux_1to4 #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .in(in8), .in_vld(in_vld),
    .A(a8), .B(b8), .C(c8), .D(d8), .out_vld(ov8)
  );

  // Reference: port p carries the word only if the input was valid and selected p.
  function automatic logic [7:0] ref_port(int p, logic [1:0] s, logic v, logic [7:0] d);
    return (v && (int'(s) == p)) ? d : 8'h00;
  endfunction

  function automatic logic [3:0] ref_vld(logic [1:0] s, logic v);
    return v ? 4'(1 << s) : 4'b0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] s, input logic v,
                           input logic [2:0] d3w, input logic [7:0] d8w);
    check({tag, " w3.A"}, 64'(a3), 64'(ref_port(0, s, v, 8'(d3w))));
    check({tag, " w3.B"}, 64'(b3), 64'(ref_port(1, s, v, 8'(d3w))));
    check({tag, " w3.C"}, 64'(c3), 64'(ref_port(2, s, v, 8'(d3w))));
    check({tag, " w3.D"}, 64'(d3), 64'(ref_port(3, s, v, 8'(d3w))));
    check({tag, " w3.vld"}, 64'(ov3), 64'(ref_vld(s, v)));
    check({tag, " w8.A"}, 64'(a8), 64'(ref_port(0, s, v, d8w)));
    check({tag, " w8.B"}, 64'(b8), 64'(ref_port(1, s, v, d8w)));
    check({tag, " w8.C"}, 64'(c8), 64'(ref_port(2, s, v, d8w)));
    check({tag, " w8.D"}, 64'(d8), 64'(ref_port(3, s, v, d8w)));
    check({tag, " w8.vld"}, 64'(ov8), 64'(ref_vld(s, v)));
    check({tag, " onehot0"}, 64'($onehot0(ov3) && $onehot0(ov8)), 64'd1);
  endtask

  task automatic check_zero(input string tag);
    check_all(tag, 2'b00, 1'b0, 3'd0, 8'h00);
  endtask

  // Apply inputs at the falling edge, let one rising edge pass, check at the next falling edge.
  task automatic step(input string tag, input logic [1:0] s, input logic v,
                      input logic [2:0] d3w, input logic [7:0] d8w);
    sel    = s;
    in_vld = v;
    in3    = d3w;
    in8    = d8w;
    @(posedge clk);
    @(negedge clk);
    check_all(tag, s, v, d3w, d8w);
  endtask

  initial begin
    rst_n  = 1'b0;
    sel    = 2'b00;
    in_vld = 1'b1;
    in3    = 3'd5;
    in8    = 8'hA5;
    #2;
    check_zero("reset_async");
    check("reset_A_const", 64'(a3), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int s = 0; s < 4; s++)
      step($sformatf("sweep_sel%0d", s), 2'(s), 1'b1, 3'd5, 8'hA5);
    check("sweep_D_const", 64'(d3), 64'd5);

    step("invalid", 2'b10, 1'b0, 3'd7, 8'h3C);
    step("revalid", 2'b10, 1'b1, 3'd7, 8'hA5);
    check("revalid_C8_const", 64'(c8), 64'hA5);

    step("zero_data", 2'b11, 1'b1, 3'd0, 8'h00);
    check("zero_data_vld_const", 64'(ov3), 64'b1000);

    step("mid_pre", 2'b01, 1'b1, 3'd6, 8'h66);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset_async");
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all("mid_release", 2'b01, 1'b1, 3'd6, 8'h66);
    check("mid_release_B_const", 64'(b3), 64'd6);

    for (int i = 0; i < 1000; i++) begin
      step("random", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           3'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/demux_1to4.md
Name: demux_1to4

Overview:
- Registered 1-to-4 demultiplexer. Routes one WIDTH-bit input word to one of four output ports (A, B, C, D) selected by a 2-bit select.
- Non-selected ports are driven to zero.
- Used as a generic steering element in datapaths that fan one source out to four consumers. Outputs are registered for clean timing at block boundaries.

Parameters:
- WIDTH, 3, data width of in and of each output port A/B/C/D; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- sel  input  2  destination select: 00→A, 01→B, 10→C, 11→D
- in  input  WIDTH  data word to steer
- in_vld  input  1  qualifies in/sel; when low, no port is driven
- A  output  WIDTH  channel 0 data
- B  output  WIDTH  channel 1 data
- C  output  WIDTH  channel 2 data
- D  output  WIDTH  channel 3 data
- out_vld  output  4  one-hot channel valid; bit0=A, bit1=B, bit2=C, bit3=D

Behaviour:
- Reset: rst_n low asynchronously forces A=B=C=D=0 and out_vld=4'b0000 immediately, with no clock required.
- Reset deassertion is synchronised by the integrating system; the block takes no special action on release.
- Latency is exactly 1 clock. On each rising clk edge with rst_n high, the registered outputs take their next values as follows.
- When in_vld=1:
  - The port indexed by sel takes in; the other three ports take 0.
  - out_vld takes the one-hot of sel: 00→0001, 01→0010, 10→0100, 11→1000.
- When in_vld=0: all four ports take 0 and out_vld takes 0000.
- Non-selected outputs are actively zeroed every cycle; previous data is never held.
- A sel change with in_vld high moves data to the new port on the next edge. The old port reads 0 in that same cycle.
- in=0 with in_vld=1 produces zero data on the selected port but still asserts its out_vld bit. Consumers rely on out_vld, not on non-zero data.
- out_vld is always one-hot or all-zero; never more than one bit set.
- Reset asserted mid-stream discards the pending word. The first valid output after release appears 1 cycle after the first sampled in_vld=1.
- No combinational path from any input to any output.
- Synthesis must give no latches and no X propagation. If sel is X/Z with in_vld=1, outputs are don't-care in simulation; the bench never drives this.

Decomposition:
- Shared package demux_pkg:
  - DEMUX_WIDTH_DEFAULT = 3.
  - sel encoding constants SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11.
  - N_PORTS = 4.
- One sub-module is natural: demux_1to4_dec. It is a combinational 2-to-4 one-hot decoder with enable: inputs sel and in_vld, output a 4-bit one-hot.
- The top masks in with each decoder bit to form the next-state of each port, and registers the data together with out_vld.

Test Plan:
- Reset: assert rst_n=0 with in=3'd5, in_vld=1, sel=00 → A=B=C=D=0 and out_vld=0000 immediately, without a clock edge.
- Sweep: rst_n=1, in=3'd5, in_vld=1, sel=00,01,10,11 on consecutive cycles → one cycle later each:
  - sel=00: A=5, B=C=D=0, out_vld=0001
  - sel=01: B=5, others 0, out_vld=0010
  - sel=10: C=5, others 0, out_vld=0100
  - sel=11: D=5, others 0, out_vld=1000
- Invalid: in=3'd7, sel=10, in_vld=0 → next cycle all ports 0 and out_vld=0000. Then raise in_vld=1 → next cycle C=7, out_vld=0100.
- Zero data: in=0, sel=11, in_vld=1 → D=0, out_vld=1000. Valid is asserted independent of data.
- Mid-stream reset: stream in=3'd6, sel=01 valid; pulse rst_n low between edges → outputs clear immediately. After release, the first edge with in_vld=1 gives B=6.
- Width: instantiate with WIDTH=8, in=8'hA5, sel=10 → C=8'hA5, others 0. Random sel/in/in_vld for 1000 cycles compared against a 1-cycle-delayed reference model. Check out_vld is always one-hot or zero.
